mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiply is shift-add over a 2*WIDTH accumulator; divide is restoring
// shift-subtract. Signed operations run on magnitudes, and the signs are
// corrected in FINISH.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] hi_lo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;          // |dividend| / |multiplicand|
    logic [WIDTH-1:0]     b_q, b_d;          // |divisor|  / |multiplier|
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;  // unmodified rs, for divide-by-zero HI
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // Combinational helpers
    logic                 signed_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       rem_sub;
    logic                 rem_ge;
    logic [2*WIDTH-1:0]   prod_fix;

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Next-state and datapath logic for the IDLE/RUN/FINISH sequencer
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        a_raw_d   = a_raw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        signed_op = ~op[0];
        a_neg     = signed_op & operand_a[WIDTH-1];
        b_neg     = signed_op & operand_b[WIDTH-1];
        a_abs     = a_neg ? -operand_a : operand_a;
        b_abs     = b_neg ? -operand_b : operand_b;

        add_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, b_q});
        rem_sub   = rem_shift - {1'b0, b_q};
        prod_fix  = neg_res_q ? -prod_q : prod_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op;
                    a_d       = a_abs;
                    b_d       = b_abs;
                    a_raw_d   = operand_a;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    prod_d    = {{WIDTH{1'b0}}, b_abs};
                    rem_d     = '0;
                    quo_d     = a_abs;
                    state_d   = S_RUN;
                end else begin
                    if (mthi) hi_d = hi_lo_wdata;
                    if (mtlo) lo_d = hi_lo_wdata;
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    rem_d = WIDTH'(rem_ge ? rem_sub : rem_shift);
                    quo_d = {quo_q[WIDTH-2:0], rem_ge};
                end else begin
                    prod_d = {add_sum, prod_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
            end
            S_FINISH: begin
                if (!op_q[1]) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_q == '0) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = neg_rem_q ? -rem_q : rem_q;
                    lo_d = neg_res_q ? -quo_q : quo_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_raw_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_raw_q   <= a_raw_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = '0;
    logic [W-1:0]  operand_a = '0;
    logic [W-1:0]  operand_b = '0;
    logic          mthi = 1'b0;
    logic          mtlo = 1'b0;
    logic [W-1:0]  hi_lo_wdata = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [63:0]   exp_q[$];

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .hi_lo_wdata(hi_lo_wdata),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: {HI, LO} for one operation
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = {32'h0, a} * {32'h0, b};
            default: begin
                if (b == 32'h0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        return p;
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] expv);
        exp_q.push_back(expv);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("busy_after_start", {31'h0, busy}, 32'h1);
    endtask

    // elapsed = cycles already spent since the start edge
    task automatic wait_done(input string tag, input int unsigned elapsed);
        int unsigned n = elapsed;
        int unsigned gaps = 0;
        logic [63:0] e;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) gaps++;
            tick();
            n++;
        end
        check({tag, "_latency"}, n, W + 1);
        check({tag, "_busy_gaps"}, gaps, 0);
        check({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
        check({tag, "_sb_pending"}, {31'h0, exp_q.size() != 0}, 32'h1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, hi, e[63:32]);
            check({tag, "_lo"}, lo, e[31:0]);
        end
    endtask

    initial begin
        int unsigned done_seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        // Reset state
        tick();
        tick();
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        reset = 1'b0;
        tick();

        // Directed arithmetic cases, issued back-to-back on each done cycle
        start_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, {32'h0000_0001, 32'hFFFF_FFFE});
        wait_done("multu_ff_x2", 0);
        start_op(2'b00, 32'hFFFF_FFFB, 32'h0000_0008, {32'hFFFF_FFFF, 32'hFFFF_FFD8});
        wait_done("mult_m5_x8", 0);
        start_op(2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000});
        wait_done("mult_min_sq", 0);
        start_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_done("div_m7_2", 0);
        start_op(2'b11, 32'd64, 32'd5, {32'd4, 32'd12});
        wait_done("divu_64_5", 0);
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
        wait_done("div_ovf", 0);
        start_op(2'b10, 32'hFFFF_FFF8, 32'h0, {32'hFFFF_FFF8, 32'hFFFF_FFFF});
        wait_done("div_m8_0", 0);
        start_op(2'b11, 32'd64, 32'h0, {32'd64, 32'hFFFF_FFFF});
        wait_done("divu_64_0", 0);
        tick();
        check("done_one_cycle", {31'h0, done}, 32'h0);

        // Start and MTHI while busy are ignored; HI/LO hold until FINISH
        start_op(2'b01, 32'd3, 32'd4, {32'h0, 32'd12});
        repeat (9) tick();
        op          = 2'b11;
        operand_a   = 32'd9;
        operand_b   = 32'd3;
        hi_lo_wdata = 32'h0000_DEAD;
        start       = 1'b1;
        mthi        = 1'b1;
        tick();
        start       = 1'b0;
        mthi        = 1'b0;
        check("hold_hi", hi, 32'd64);
        check("hold_lo", lo, 32'hFFFF_FFFF);
        wait_done("busy_ignore", 10);
        tick();
        check("ignored_no_done", {31'h0, done}, 32'h0);
        check("ignored_no_busy", {31'h0, busy}, 32'h0);
        check("ignored_mthi", hi, 32'h0);

        // Reset in the middle of an operation discards it
        op        = 2'b01;
        operand_a = 32'd5;
        operand_b = 32'd7;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);

        // MTHI in IDLE, then MTLO colliding with start
        hi_lo_wdata = 32'h0000_1234;
        mthi        = 1'b1;
        tick();
        mthi        = 1'b0;
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo", lo, 32'h0);
        hi_lo_wdata = 32'h0000_5555;
        mtlo        = 1'b1;
        start_op(2'b01, 32'd2, 32'd3, {32'h0, 32'd6});
        mtlo        = 1'b0;
        check("mtlo_dropped_lo", lo, 32'h0);
        check("mtlo_dropped_hi", hi, 32'h0000_1234);
        wait_done("multu_2_3", 0);

        // Random operations, each started in the previous done cycle
        for (int k = 0; k < 8; k++) begin
            ro = 2'($urandom_range(3));
            ra = $urandom();
            rb = (k == 3) ? 32'h0 : ((k % 2) == 0 ? $urandom() : 32'($urandom_range(1, 300)));
            start_op(ro, ra, rb, model(ro, ra, rb));
            wait_done("rand", 0);
        end
        tick();
        check("final_idle_done", {31'h0, done}, 32'h0);
        check("final_idle_busy", {31'h0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
